ac97_playback_fifo: RTL and testbench

Playback sample buffer between the DMA read engine and the AC'97 downlink framer.
- Accepts 32-bit stereo words (left in [31:16], right in [15:0]) from the DMA side over a valid/ready handshake.
- Hands one sample pair to the framer per frame request, as 20-bit slot data (16-bit sample left-justified, 4 LSBs zero).
- Absorbs bus latency, signals refill demand against a programmable low-water mark, and flags underruns.

---
 rtl/ac97_playback_fifo.sv | 136 +++++++++++++
 tb/tb_ac97_playback_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_playback_fifo.sv
// Playback sample FIFO between the DMA read engine and the AC'97 downlink framer.
// Buffers 32-bit stereo words and hands one 20-bit left/right slot pair to the framer per frame request.
module ac97_playback_fifo #(
    parameter int depth_log2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  en,
    input  logic                  in_stb,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    input  logic [depth_log2:0]   low_water,
    output logic                  refill_req,
    output logic [depth_log2:0]   level,
    input  logic                  next_frame,
    output logic                  pcmleft_valid,
    output logic [19:0]           pcmleft,
    output logic                  pcmright_valid,
    output logic [19:0]           pcmright,
    output logic                  underrun,
    input  logic                  underrun_clr
);

    localparam int LW = depth_log2 + 1;
    localparam int DEPTH = 1 << depth_log2;
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

    logic [31:0]           mem_q [DEPTH];
    logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  valid_q, valid_d;
    logic [19:0]           pcmleft_q, pcmleft_d;
    logic [19:0]           pcmright_q, pcmright_d;
    logic                  underrun_q, underrun_d;
    logic                  refill_q, refill_d;

    logic        full, empty;
    logic        ready_c;
    logic        push, pop_req, pop, starve;
    logic [31:0] rd_word;

    always_comb begin
        full    = (level_q == DEPTH_LVL);
        empty   = (level_q == '0);
        // Held low during reset so no handshake completes while the block is being cleared.
        ready_c = en & ~full & sys_rst_n;
        push    = in_stb & ready_c;
        pop_req = next_frame & en;
        pop     = pop_req & ~empty;
        starve  = pop_req & empty;
        rd_word = mem_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        valid_d    = valid_q;
        pcmleft_d  = pcmleft_q;
        pcmright_d = pcmright_q;

        if (!en) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            valid_d    = 1'b0;
            pcmleft_d  = '0;
            pcmright_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                valid_d    = 1'b1;
                pcmleft_d  = {rd_word[31:16], 4'h0};
                pcmright_d = {rd_word[15:0], 4'h0};
            end else if (starve) begin
                valid_d    = 1'b0;
                pcmleft_d  = '0;
                pcmright_d = '0;
            end
            level_d = level_q + LW'(push) - LW'(pop);
        end

        // A fresh underrun outranks a simultaneous clear; disabled playback never starves.
        underrun_d = underrun_q;
        if (starve) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        refill_d = en & (level_d <= low_water);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            pcmleft_q  <= '0;
            pcmright_q <= '0;
            underrun_q <= 1'b0;
            refill_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            pcmleft_q  <= pcmleft_d;
            pcmright_q <= pcmright_d;
            underrun_q <= underrun_d;
            refill_q   <= refill_d;
        end
    end

    // Storage needs no reset; push is already gated off while reset is asserted.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready       = ready_c;
    assign refill_req     = refill_q;
    assign level          = level_q;
    assign pcmleft_valid  = valid_q;
    assign pcmright_valid = valid_q;
    assign pcmleft        = pcmleft_q;
    assign pcmright       = pcmright_q;
    assign underrun       = underrun_q;

endmodule

// File: tb/tb_ac97_playback_fifo.sv
// Directed self-checking bench for ac97_playback_fifo with hand-computed expected values.
module tb_ac97_playback_fifo;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        en;
    logic        in_stb;
    logic [31:0] in_data;
    logic        in_ready;
    logic [4:0]  low_water;
    logic        refill_req;
    logic [4:0]  level;
    logic        next_frame;
    logic        pcmleft_valid;
    logic [19:0] pcmleft;
    logic        pcmright_valid;
    logic [19:0] pcmright;
    logic        underrun;
    logic        underrun_clr;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    ac97_playback_fifo #(.depth_log2(4)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .en(en),
        .in_stb(in_stb),
        .in_data(in_data),
        .in_ready(in_ready),
        .low_water(low_water),
        .refill_req(refill_req),
        .level(level),
        .next_frame(next_frame),
        .pcmleft_valid(pcmleft_valid),
        .pcmleft(pcmleft),
        .pcmright_valid(pcmright_valid),
        .pcmright(pcmright),
        .underrun(underrun),
        .underrun_clr(underrun_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] word);
        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        check_eq({tag, "_valid"}, {pcmright_valid, pcmleft_valid}, 32'h3);
        check_eq({tag, "_left"}, pcmleft, {word[31:16], 4'h0});
        check_eq({tag, "_right"}, pcmright, {word[15:0], 4'h0});
    endtask

    initial begin
        logic [31:0] q [$];
        logic [31:0] w;

        sys_rst_n    = 1'b0;
        en           = 1'b1;
        in_stb       = 1'b1;
        in_data      = 32'hDEAD_BEEF;
        low_water    = 5'd0;
        next_frame   = 1'b0;
        underrun_clr = 1'b0;

        // Reset held two cycles with en and in_stb high
        tick();
        tick();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_valid", {pcmleft_valid, pcmright_valid}, 0);
        check_eq("rst_refill", refill_req, 0);
        check_eq("rst_pcm", {pcmleft, pcmright}, 0);

        sys_rst_n = 1'b1;
        in_stb    = 1'b0;
        tick();
        check_eq("idle_level", level, 0);
        check_eq("idle_in_ready", in_ready, 1);

        // Fill to full
        for (int i = 1; i <= 16; i++) begin
            in_data = {16'(i), 16'(2 * i)};
            in_stb  = 1'b1;
            tick();
        end
        in_stb = 1'b0;
        check_eq("full_level", level, 16);
        check_eq("full_in_ready", in_ready, 0);

        // Push at full is ignored, even with a pop in the same cycle
        in_data    = 32'hFFFF_FFFF;
        in_stb     = 1'b1;
        tick();
        check_eq("full_reject_level", level, 16);
        next_frame = 1'b1;
        tick();
        in_stb     = 1'b0;
        next_frame = 1'b0;
        check_eq("full_pop_push_level", level, 15);
        check_eq("full_pop_left", pcmleft, 20'h00010);
        check_eq("full_pop_right", pcmright, 20'h00020);

        for (int i = 2; i <= 16; i++) begin
            pop_check("drain", {16'(i), 16'(2 * i)});
        end
        check_eq("drain_level", level, 0);
        tick();
        check_eq("hold_left", pcmleft, 20'h00100);
        check_eq("hold_right", pcmright, 20'h00200);
        check_eq("hold_valid", pcmleft_valid, 1);

        // Wrap: push 10, pop 5, then simultaneous push/pop for 40 cycles
        for (int i = 0; i < 10; i++) begin
            w       = 32'h0100_0000 + 32'(i * 3);
            q.push_back(w);
            in_data = w;
            in_stb  = 1'b1;
            tick();
        end
        in_stb = 1'b0;
        check_eq("wrap_level10", level, 10);
        for (int i = 0; i < 5; i++) begin
            w = q.pop_front();
            pop_check("wrap_pop", w);
        end
        check_eq("wrap_level5", level, 5);
        for (int i = 0; i < 40; i++) begin
            w          = 32'hA000_0000 + 32'(i * 32'h0001_0007);
            q.push_back(w);
            in_data    = w;
            in_stb     = 1'b1;
            w          = q.pop_front();
            pop_check("sim", w);
            check_eq("sim_level", level, 5);
        end
        in_stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = q.pop_front();
            pop_check("wrap_tail", w);
        end
        check_eq("wrap_empty", level, 0);

        // Underrun on empty
        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        check_eq("ur_valid", {pcmleft_valid, pcmright_valid}, 0);
        check_eq("ur_data", {pcmleft, pcmright}, 0);
        check_eq("ur_flag", underrun, 1);

        // Push into empty alongside next_frame: no fall-through
        in_data    = 32'hABCD_1234;
        in_stb     = 1'b1;
        next_frame = 1'b1;
        tick();
        in_stb     = 1'b0;
        next_frame = 1'b0;
        check_eq("nofall_level", level, 1);
        check_eq("nofall_valid", pcmleft_valid, 0);
        check_eq("nofall_ur", underrun, 1);

        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check_eq("ur_clr", underrun, 0);

        pop_check("ur_word", 32'hABCD_1234);
        check_eq("ur_word_left_lit", pcmleft, 20'hABCD0);
        check_eq("ur_word_right_lit", pcmright, 20'h12340);

        // Set wins over clear
        next_frame   = 1'b1;
        underrun_clr = 1'b1;
        tick();
        next_frame   = 1'b0;
        underrun_clr = 1'b0;
        check_eq("ur_set_wins", underrun, 1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check_eq("ur_clr2", underrun, 0);

        // Threshold at 4
        low_water = 5'd4;
        tick();
        check_eq("thr_level0", refill_req, 1);
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h0050_0000 + 32'(i);
            in_stb  = 1'b1;
            tick();
        end
        in_stb = 1'b0;
        check_eq("thr_level5", level, 5);
        check_eq("thr_refill5", refill_req, 0);
        pop_check("thr_pop", 32'h0050_0000);
        check_eq("thr_level4", level, 4);
        check_eq("thr_refill4", refill_req, 1);

        // Flush at level 7
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h0060_0000 + 32'(i);
            in_stb  = 1'b1;
            tick();
        end
        in_stb = 1'b0;
        check_eq("fl_level7", level, 7);
        en = 1'b0;
        #1;
        check_eq("fl_in_ready", in_ready, 0);
        tick();
        check_eq("fl_level", level, 0);
        check_eq("fl_valid", {pcmleft_valid, pcmright_valid}, 0);
        check_eq("fl_data", {pcmleft, pcmright}, 0);
        check_eq("fl_refill", refill_req, 0);

        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        check_eq("dis_nf_ur0", underrun, 0);

        en = 1'b1;
        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        check_eq("en_ur_set", underrun, 1);
        en = 1'b0;
        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        check_eq("dis_ur_hold", underrun, 1);

        // Pointers restart at 0 after flush
        en = 1'b1;
        underrun_clr = 1'b1;
        in_data = 32'h1357_2468;
        in_stb  = 1'b1;
        tick();
        in_stb = 1'b0;
        underrun_clr = 1'b0;
        check_eq("post_fl_level", level, 1);
        pop_check("post_fl", 32'h1357_2468);

        // Threshold at/above depth keeps refill asserted
        low_water = 5'd16;
        for (int i = 0; i < 16; i++) begin
            in_data = 32'(i);
            in_stb  = 1'b1;
            tick();
        end
        in_stb = 1'b0;
        check_eq("lw_depth_full", level, 16);
        check_eq("lw_depth_refill", refill_req, 1);

        // Reset mid-operation
        sys_rst_n = 1'b0;
        in_stb    = 1'b1;
        tick();
        check_eq("mid_rst_level", level, 0);
        check_eq("mid_rst_valid", pcmleft_valid, 0);
        check_eq("mid_rst_refill", refill_req, 0);
        sys_rst_n = 1'b1;
        in_stb    = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
